// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    localparam int REG_BUS        = 32;
    localparam int DOUBLE_REG_BUS = 64;

    // Controller states; the codes match the rest of the pipeline.
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // One restoring step per cycle; after this many steps the quotient is complete.
    localparam logic [5:0] DIV_STEPS = 6'd32;

    // Magnitude of an operand; only negative values in signed mode are negated.
    function automatic logic [REG_BUS-1:0] abs_if_signed(input logic [REG_BUS-1:0] v,
                                                        input logic sgn);
        return (sgn && v[REG_BUS-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Iterative 32-bit signed/unsigned restoring divider for the execute stage.
// Produces {remainder, quotient}; handles divide-by-zero and pipeline annul.
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e                state_reg, state_next;
    logic [5:0]                cnt_reg, cnt_next;
    logic [64:0]               dividend_reg, dividend_next;
    logic [REG_BUS-1:0]        divisor_reg, divisor_next;
    logic                      neg_quot_reg, neg_quot_next;
    logic                      neg_rem_reg, neg_rem_next;
    logic [DOUBLE_REG_BUS-1:0] result_reg, result_next;
    logic                      ready_reg, ready_next;

    logic [32:0]               diff;
    logic [REG_BUS-1:0]        quot_fix;
    logic [REG_BUS-1:0]        rem_fix;

    // Trial subtraction of the divisor from the upper partial remainder, plus sign fix-up.
    always_comb begin
        diff     = {1'b0, dividend_reg[63:32]} - {1'b0, divisor_reg};
        quot_fix = neg_quot_reg ? (~dividend_reg[31:0] + 1'b1) : dividend_reg[31:0];
        rem_fix  = neg_rem_reg  ? (~dividend_reg[64:33] + 1'b1) : dividend_reg[64:33];
    end

    // Next-state and datapath control for the divide sequence.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        dividend_next = dividend_reg;
        divisor_next  = divisor_reg;
        neg_quot_next = neg_quot_reg;
        neg_rem_next  = neg_rem_reg;
        result_next   = result_reg;
        ready_next    = ready_reg;

        case (state_reg)
            DIV_FREE: begin
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_next = DIV_BY_ZERO;
                    end else begin
                        state_next    = DIV_ON;
                        cnt_next      = '0;
                        dividend_next = {32'b0, abs_if_signed(opdata1_i, signed_div_i), 1'b0};
                        divisor_next  = abs_if_signed(opdata2_i, signed_div_i);
                        // Keep the original signs; the magnitudes lose them.
                        neg_quot_next = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_next  = signed_div_i && opdata1_i[31];
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_next  = DIV_END;
                result_next = '0;
                ready_next  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_next  = DIV_FREE;
                    cnt_next    = '0;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else if (cnt_reg != DIV_STEPS) begin
                    // Negative diff means the divisor did not fit: shift in a 0.
                    if (diff[32]) begin
                        dividend_next = {dividend_reg[63:0], 1'b0};
                    end else begin
                        dividend_next = {diff[31:0], dividend_reg[31:0], 1'b1};
                    end
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = DIV_END;
                    cnt_next    = '0;
                    result_next = {rem_fix, quot_fix};
                    ready_next  = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                // start_i held high is only a hold; dropping it releases the result.
                if (start_i == DIV_STOP) begin
                    state_next  = DIV_FREE;
                    cnt_next    = '0;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_next = DIV_FREE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= DIV_FREE;
            cnt_reg      <= '0;
            dividend_reg <= '0;
            divisor_reg  <= '0;
            neg_quot_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            result_reg   <= '0;
            ready_reg    <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dividend_reg <= dividend_next;
            divisor_reg  <= divisor_next;
            neg_quot_reg <= neg_quot_next;
            neg_rem_reg  <= neg_rem_next;
            result_reg   <= result_next;
            ready_reg    <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the iterative divider: arithmetic reference model,
// per-cycle output comparison, and directed vectors with literal expectations.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result_o;
    logic        ready_o;

    int checks   = 0;
    int failures = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Truncating division computed in 64-bit arithmetic, so the signed overflow
    // case needs no special handling; divide-by-zero yields all zeros.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        if (b == 0) return 64'd0;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: idle / busy for a fixed number of cycles / done.
    int          m_mode;      // 0 idle, 1 busy, 2 done
    int          m_left;
    logic        m_dbz;
    logic [63:0] m_pend;
    logic        exp_ready;
    logic [63:0] exp_result;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode     <= 0;
            m_left     <= 0;
            m_dbz      <= 1'b0;
            m_pend     <= '0;
            exp_ready  <= 1'b0;
            exp_result <= '0;
        end else begin
            case (m_mode)
                0: begin
                    exp_ready  <= 1'b0;
                    exp_result <= '0;
                    if (start && !annul) begin
                        m_mode <= 1;
                        m_dbz  <= (op2 == 0);
                        m_left <= (op2 == 0) ? 1 : 33;
                        m_pend <= ref_div(op1, op2, signed_div);
                    end
                end
                1: begin
                    if (annul && !m_dbz) begin
                        m_mode <= 0;
                    end else if (m_left == 1) begin
                        m_mode     <= 2;
                        exp_ready  <= 1'b1;
                        exp_result <= m_pend;
                    end else begin
                        m_left <= m_left - 1;
                    end
                end
                default: begin
                    if (!start) begin
                        m_mode     <= 0;
                        exp_ready  <= 1'b0;
                        exp_result <= '0;
                    end
                end
            endcase
        end
    end

    // Compare outputs against the model on every falling edge.
    bit cmp_en = 1'b1;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle ready", {63'b0, ready_o}, {63'b0, exp_ready});
            check("cycle result", result_o, exp_result);
        end
    end

    // One full request/hold/release sequence; called on a falling edge.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] lit, input int lat);
        int cyc;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        @(negedge clk);
        cyc = 1;
        // Operands are scrambled after capture; the result must not change.
        op1 = $urandom;
        op2 = $urandom;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " result"}, result_o, lit);
        // annul during the hold has no effect.
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        @(negedge clk);
        check({name, " hold"}, result_o, lit);
        start = 1'b0;
        @(negedge clk);
        check({name, " cleared"}, {ready_o, result_o[62:0]}, 64'd0);
        $display("txn %s a=%h b=%h signed=%0d result=%h cycles=%0d", name, a, b, sgn, lit, cyc);
    endtask

    initial begin
        int cyc;
        rst        = 1'b0;
        signed_div = 1'b0;
        op1        = '0;
        op2        = '0;
        start      = 1'b0;
        annul      = 1'b0;

        // Pin the model with hand-computed values.
        check("model 100/7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("model -7/2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("model ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});

        repeat (3) @(negedge clk);
        check("reset state", {ready_o, result_o[62:0]}, 64'd0);
        #2 rst = 1'b1;
        @(negedge clk);

        run_div("u100/7",   32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 34);
        run_div("s-7/2",    32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34);
        run_div("s ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, {32'd0, 32'h80000000}, 34);
        run_div("uFFFF/1",  32'hFFFFFFFF,   32'd1,          1'b0, {32'd0, 32'hFFFFFFFF}, 34);
        run_div("s7/-2",    32'd7,          32'hFFFFFFFE,   1'b1, {32'd1, 32'hFFFFFFFD}, 34);
        run_div("uFFF9/2",  32'hFFFFFFF9,   32'd2,          1'b0, {32'd1, 32'h7FFFFFFC}, 34);
        run_div("s-100/-7", 32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, {32'hFFFFFFFE, 32'd14}, 34);
        run_div("div0",     32'h12345678,   32'd0,          1'b0, 64'd0, 2);

        // Annul at E10, then an immediate 9/3 request.
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        check("annul no ready", {63'b0, ready_o}, 64'd0);
        annul = 1'b0;
        op1   = 32'd9;
        op2   = 32'd3;
        cyc   = 0;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("annul next latency", 64'(cyc), 64'd34);
        check("annul next result", result_o, {32'd0, 32'd3});
        $display("txn annul 1000/3 then 9/3 result=%h cycles=%0d", result_o, cyc);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-division.
        op1   = 32'd1000;
        op2   = 32'd3;
        start = 1'b1;
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst mid-div", {ready_o, result_o[62:0]}, 64'd0);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        $display("txn reset mid-division");
        run_div("u50/5", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 34);

        // Asynchronous reset while a non-zero result is being held.
        op1   = 32'd100;
        op2   = 32'd7;
        start = 1'b1;
        cyc   = 0;
        while (!ready_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("held result", result_o, {32'd2, 32'd14});
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("rst held ready", {63'b0, ready_o}, 64'd0);
        check("rst held result", result_o, 64'd0);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        $display("txn reset while holding result");
        repeat (2) @(negedge clk);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div.md
# div

Iterative 32-bit signed/unsigned divider serving as the execute stage's multi-cycle responder. EX raises `start_i` with two operands, holds its stall request while `ready_o` is low, and consumes `{remainder, quotient}` when `ready_o` rises. It uses restoring division with one quotient bit per cycle, with explicit divide-by-zero and annul paths.

## Interface
Parameters:
- none. Widths come from `defines.v` (`RegBus` = 32, `DoubleRegBus` = 64).

Ports:
- `clk`  in  1  System clock. All state changes on the rising edge.
- `rst`  in  1  Reset. Asynchronous and active-low (`RstEnable` = 1'b0).
- `signed_div_i`  in  1  1 = signed division (DIV), 0 = unsigned division (DIVU). Sampled with `start_i`.
- `opdata1_i`  in  32  Dividend. Sampled with `start_i`.
- `opdata2_i`  in  32  Divisor. Sampled with `start_i`.
- `start_i`  in  1  Request. Must be held high by EX until it has seen `ready_o`.
- `annul_i`  in  1  Abort the in-flight division (pipeline flush).
- `result_o`  out  64  `{remainder[31:0], quotient[31:0]}`. Registered.
- `ready_o`  out  1  Result valid. Registered.

## Operation
- FSM states and codes (`defines.v`): `DivFree` 2'b00, `DivByZero` 2'b01, `DivOn` 2'b10, `DivEnd` 2'b11.
- **DivFree**
  - `start_i`=1, `annul_i`=0, divisor ≠ 0 → capture operands → `DivOn`, with `cnt`=0.
  - `start_i`=1, `annul_i`=0, divisor = 0 → `DivByZero`.
  - Otherwise stay in `DivFree`. `ready_o`=0, `result_o`=0.
- **Operand conditioning at capture (signed mode only)**
  - A negative operand is replaced by its two's complement (absolute value).
  - The original sign bits are kept for the final fix-up.
- **DivOn**
  - Working register `dividend`: 65 bits. Initialised to `{32'b0, |dividend|, 1'b0}`.
  - Each cycle while `cnt` < 32:
    - `diff = dividend[63:32] - |divisor|`, computed 33 bits wide.
    - If `diff` is negative: `dividend <= dividend << 1`.
    - Else: `dividend <= {diff[31:0], dividend[31:0], 1'b1}`.
    - `cnt <= cnt + 1`.
  - When `cnt` = 32: quotient = `dividend[31:0]`, remainder = `dividend[64:33]`.
    - Signed mode, operand signs differ → negate the quotient.
    - Signed mode, dividend negative → negate the remainder.
    - Load `result_o`, set `ready_o`=1, go to `DivEnd`.
  - `annul_i`=1 in any `DivOn` cycle → `DivFree` on that edge. No result is produced and `ready_o` stays 0.
- **DivByZero**: one cycle, then `DivEnd` with `result_o`=0 and `ready_o`=1.
- **DivEnd**
  - Hold `result_o` and `ready_o`=1 while `start_i`=1.
  - `start_i`=0 → `DivFree`, clearing `ready_o` and `result_o` to 0.
- **Overflow case, signed 0x80000000 / 0xFFFFFFFF**: quotient 0x80000000, remainder 0. No exception is raised.
- **Operand changes**: changes on `opdata*_i` after capture are ignored until the unit returns to `DivFree`.

## Timing
- **Reset**: `rst` low asynchronously forces `DivFree`, `cnt`=0, `ready_o`=0, `result_o`=0. This holds at any point, including mid-division. Leaving reset is synchronous to `clk`.
- **Latency, normal divide** (edge sampling `start_i` = E1):
  - E2..E33: 32 iteration steps.
  - E34: finalise the result.
  - `ready_o` is high after E34.
- **Latency, divide-by-zero**: E1 → `DivByZero`; E2 → `DivEnd`; `ready_o` is high after E2.
- **Back-to-back requests**: EX must drop `start_i` for at least one cycle after `ready_o`. `start_i` high in `DivEnd` is a hold, never a new request.
- **annul_i**
  - Has priority over `start_i` in `DivFree`.
  - In `DivOn`, returns the unit to `DivFree` on the same edge.
  - In `DivEnd`/`DivByZero` it has no effect; the `start_i` drop does the clearing.
- **Combinational paths**: none from inputs to outputs.

## Structure
- Add to `defines.v`:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd`
  - `DivResultReady`/`DivResultNotReady` (1'b1/1'b0)
  - `DivStart`/`DivStop` (1'b1/1'b0)
  - `DoubleRegBus` (63:0)
- Single module. No sub-module: the 33-bit subtract and the sign negations are inline.
- Connection to EX:
  - EX drives `start_i`, `signed_div_i` and the operands.
  - EX asserts `stallreq_o` while `start_i` && !`ready_o`.
  - EX selects `result_o` onto HI/LO.

## Test plan
- Unsigned 100 / 7 → `ready_o` high after E34; `result_o` = {32'd2, 32'd14}.
- Signed -7 / 2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF, remainder 0.
- Divisor 0, dividend 0x12345678 → `ready_o` high after E2, `result_o` = 0; holds while `start_i`=1; clears one cycle after `start_i`=0.
- Start 1000 / 3, assert `annul_i` at E10 → `DivFree` at E10 with `ready_o` never high. An immediate new request 9 / 3 then yields {0, 3}.
- Assert `rst` low asynchronously mid-division (between edges, at E20) → `ready_o`=0 and `result_o`=0 immediately. After release, a fresh 50 / 5 returns {0, 10}.
